ramp_gen_param: RTL and testbench

- Parametrised ramp generator that acts as a consumer on a dav_/rfd handshake.
- Each accepted request carries a direction, a step count, a step size and an end mode. The block then ramps `out` from its current value by ±step once per clock for the requested number of steps.
- It then waits for the producer to release dav_. Depending on the request mode, `out` either returns to mid-scale or holds its final value.
- Successor to the fixed 8-bit, unit-step, always-return ramp unit. Adds configurable widths, step size, saturation and hold mode.

---
 rtl/ramp_gen_param_if.sv | 28 ++
 rtl/ramp_gen_param.sv | 135 +++++++++++++
 tb/tb_ramp_gen_param.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ramp_gen_param_if.sv
// Handshake and data bundle between a ramp request producer and the ramp
// generator. The producer (master) drives the request fields and the
// active-low data-valid; the generator (slave) returns ready-for-data,
// the ramp value and the done flag.
interface ramp_gen_param_if #(
    parameter int OUT_W  = 8,
    parameter int CNT_W  = 7,
    parameter int STEP_W = 3
);
    logic              dav_;
    logic              rfd;
    logic              s;
    logic [CNT_W-1:0]  h;
    logic [STEP_W-1:0] k;
    logic              m;
    logic [OUT_W-1:0]  out;
    logic              done;

    modport master (
        output dav_, s, h, k, m,
        input  rfd, out, done
    );

    modport slave (
        input  dav_, s, h, k, m,
        output rfd, out, done
    );
endinterface

// File: rtl/ramp_gen_param.sv
// Parametrised ramp generator. Accepts one request per dav_/rfd handshake,
// steps the output by +/-k once per clock for h clocks (saturating or
// wrapping), then waits for the producer to release dav_ while either
// returning to mid-scale or holding the final value.
module ramp_gen_param #(
    parameter int OUT_W  = 8,
    parameter int CNT_W  = 7,
    parameter int STEP_W = 3,
    parameter int SAT    = 1
) (
    input  logic            clock,
    input  logic            reset_,
    ramp_gen_param_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT
    } state_t;

    localparam logic [OUT_W-1:0] MID     = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] TOP     = {OUT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_nxt;
    logic                rfd_q, rfd_nxt;
    logic                done_q, done_nxt;
    logic [OUT_W-1:0]    out_q, out_nxt;
    logic                s_q, s_nxt;
    logic                m_q, m_nxt;
    logic [STEP_W-1:0]   k_q, k_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;

    logic [OUT_W:0]      k_ext;
    logic [OUT_W:0]      sum_up;
    logic [OUT_W:0]      diff_dn;
    logic [OUT_W-1:0]    step_val;

    // Next ramp value: one extra bit exposes overflow/borrow, then clamp or wrap.
    always_comb begin
        k_ext               = '0;
        k_ext[STEP_W-1:0]   = k_q;
        sum_up              = {1'b0, out_q} + k_ext;
        diff_dn             = {1'b0, out_q} - k_ext;
        step_val            = out_q;
        if (!s_q) begin
            if ((SAT != 0) && sum_up[OUT_W]) begin
                step_val = TOP;
            end else begin
                step_val = sum_up[OUT_W-1:0];
            end
        end else begin
            if ((SAT != 0) && diff_dn[OUT_W]) begin
                step_val = '0;
            end else begin
                step_val = diff_dn[OUT_W-1:0];
            end
        end
    end

    // Next-state and next-output decode for the IDLE/RUN/WAIT controller.
    always_comb begin
        state_nxt = state_q;
        rfd_nxt   = rfd_q;
        done_nxt  = done_q;
        out_nxt   = out_q;
        s_nxt     = s_q;
        m_nxt     = m_q;
        k_nxt     = k_q;
        cnt_nxt   = cnt_q;
        case (state_q)
            IDLE: begin
                rfd_nxt = 1'b1;
                if (rfd_q && !bus.dav_) begin
                    s_nxt     = bus.s;
                    m_nxt     = bus.m;
                    k_nxt     = bus.k;
                    cnt_nxt   = bus.h;
                    rfd_nxt   = 1'b0;
                    state_nxt = (bus.h != '0) ? RUN : WAIT;
                end
            end
            RUN: begin
                out_nxt = step_val;
                cnt_nxt = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_nxt = WAIT;
                    done_nxt  = 1'b1;
                end
            end
            WAIT: begin
                rfd_nxt  = 1'b0;
                done_nxt = 1'b1;
                if (!m_q) begin
                    out_nxt = MID;
                end
                if (bus.dav_) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b0;
                    rfd_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q <= IDLE;
            rfd_q   <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= MID;
            s_q     <= 1'b0;
            m_q     <= 1'b0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            rfd_q   <= rfd_nxt;
            done_q  <= done_nxt;
            out_q   <= out_nxt;
            s_q     <= s_nxt;
            m_q     <= m_nxt;
            k_q     <= k_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign bus.rfd  = rfd_q;
    assign bus.done = done_q;
    assign bus.out  = out_q;
endmodule

// File: tb/tb_ramp_gen_param.sv
// Bench for ramp_gen_param: a saturating and a wrapping instance share the
// same stimulus; expected ramp values come from plain integer arithmetic.
module tb_ramp_gen_param;
    logic       clock;
    logic       reset_;
    logic       dav_n;
    logic       s_i;
    logic [6:0] h_i;
    logic [2:0] k_i;
    logic       m_i;

    int checks;
    int errors;
    int exp_sat;
    int exp_wrap;

    ramp_gen_param_if #(.OUT_W(8), .CNT_W(7), .STEP_W(3)) bus_sat ();
    ramp_gen_param_if #(.OUT_W(8), .CNT_W(7), .STEP_W(3)) bus_wrap ();

    assign bus_sat.dav_  = dav_n;
    assign bus_sat.s     = s_i;
    assign bus_sat.h     = h_i;
    assign bus_sat.k     = k_i;
    assign bus_sat.m     = m_i;
    assign bus_wrap.dav_ = dav_n;
    assign bus_wrap.s    = s_i;
    assign bus_wrap.h    = h_i;
    assign bus_wrap.k    = k_i;
    assign bus_wrap.m    = m_i;

    ramp_gen_param #(.OUT_W(8), .CNT_W(7), .STEP_W(3), .SAT(1)) dut_sat (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus_sat.slave)
    );

    ramp_gen_param #(.OUT_W(8), .CNT_W(7), .STEP_W(3), .SAT(0)) dut_wrap (
        .clock  (clock),
        .reset_ (reset_),
        .bus    (bus_wrap.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int next_val(input int cur, input logic dn, input int step, input bit sat);
        int r;
        r = dn ? cur - step : cur + step;
        if (sat) begin
            if (r > 255) r = 255;
            if (r < 0) r = 0;
        end else begin
            r = ((r % 256) + 256) % 256;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag);
        logic [15:0] got;
        logic [15:0] want;
        got  = {bus_sat.out, bus_wrap.out};
        want = {8'(exp_sat), 8'(exp_wrap)};
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s out(sat,wrap): got %h expected %h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic check_flags(input string tag, input logic rfd_e, input logic done_e);
        logic [3:0] got;
        logic [3:0] want;
        got  = {bus_sat.rfd, bus_wrap.rfd, bus_sat.done, bus_wrap.done};
        want = {rfd_e, rfd_e, done_e, done_e};
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s rfd/done: got %b expected %b at %0t", tag, got, want, $time);
        end
    endtask

    task automatic do_reset(input string tag);
        reset_ = 1'b0;
        dav_n  = 1'b1;
        tick();
        tick();
        exp_sat  = 128;
        exp_wrap = 128;
        check_out({tag, "_in_reset"});
        check_flags({tag, "_in_reset"}, 1'b0, 1'b0);
        reset_ = 1'b1;
        tick();
        check_flags({tag, "_rfd_rise"}, 1'b1, 1'b0);
    endtask

    // One full transaction: handshake, h steps with noisy inputs, WAIT, release.
    task automatic run_request(input string tag, input logic rs, input int rh, input int rk,
                               input logic rm, input int wait_cycles);
        int budget;
        budget = 0;
        while ((bus_sat.rfd !== 1'b1 || bus_wrap.rfd !== 1'b1) && budget < 20) begin
            tick();
            budget++;
        end
        checks++;
        if (bus_sat.rfd !== 1'b1 || bus_wrap.rfd !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s rfd_wait: got %b%b expected 11 within 20 cycles", tag,
                     bus_sat.rfd, bus_wrap.rfd);
        end
        s_i   = rs;
        h_i   = 7'(rh);
        k_i   = 3'(rk);
        m_i   = rm;
        dav_n = 1'b0;
        tick();
        check_out({tag, "_accept"});
        check_flags({tag, "_accept"}, 1'b0, 1'b0);
        for (int i = 1; i <= rh; i++) begin
            s_i   = 1'($urandom);
            h_i   = 7'($urandom);
            k_i   = 3'($urandom);
            m_i   = 1'($urandom);
            dav_n = 1'($urandom);
            tick();
            exp_sat  = next_val(exp_sat, rs, rk, 1'b1);
            exp_wrap = next_val(exp_wrap, rs, rk, 1'b0);
            check_out({tag, "_step"});
            check_flags({tag, "_step"}, 1'b0, (i == rh));
        end
        dav_n = 1'b0;
        for (int w = 0; w < wait_cycles; w++) begin
            tick();
            if (!rm) begin
                exp_sat  = 128;
                exp_wrap = 128;
            end
            check_out({tag, "_wait"});
            check_flags({tag, "_wait"}, 1'b0, 1'b1);
        end
        dav_n = 1'b1;
        tick();
        if (!rm) begin
            exp_sat  = 128;
            exp_wrap = 128;
        end
        check_out({tag, "_release"});
        check_flags({tag, "_release"}, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_basic_return();
        run_request("basic", 1'b0, 5, 1, 1'b0, 0);
    endtask

    task automatic test_hold_mode();
        run_request("hold_dn", 1'b1, 3, 2, 1'b1, 2);
        checks++;
        if (bus_sat.out !== 8'h7A || bus_wrap.out !== 8'h7A) begin
            errors++;
            $display("[TB] FAIL hold_value: got %h/%h expected 7a", bus_sat.out, bus_wrap.out);
        end
        run_request("hold_up", 1'b0, 1, 1, 1'b1, 0);
        checks++;
        if (bus_sat.out !== 8'h7B || bus_wrap.out !== 8'h7B) begin
            errors++;
            $display("[TB] FAIL hold_next: got %h/%h expected 7b", bus_sat.out, bus_wrap.out);
        end
    endtask

    task automatic test_saturation();
        do_reset("sat_reset");
        run_request("sat", 1'b0, 100, 7, 1'b1, 1);
        checks++;
        if (bus_sat.out !== 8'hFF || bus_wrap.out !== 8'h3C) begin
            errors++;
            $display("[TB] FAIL sat_final: got %h/%h expected ff/3c", bus_sat.out, bus_wrap.out);
        end
    endtask

    task automatic test_zero_length();
        run_request("zero_len", 1'b0, 0, 5, 1'b1, 10);
    endtask

    task automatic test_reset_mid_ramp();
        while (bus_sat.rfd !== 1'b1) tick();
        s_i   = 1'b0;
        h_i   = 7'd10;
        k_i   = 3'd3;
        m_i   = 1'b0;
        dav_n = 1'b0;
        tick();
        dav_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_sat  = next_val(exp_sat, 1'b0, 3, 1'b1);
            exp_wrap = next_val(exp_wrap, 1'b0, 3, 1'b0);
            check_out("midreset_step");
        end
        reset_ = 1'b0;
        tick();
        exp_sat  = 128;
        exp_wrap = 128;
        check_out("midreset_out");
        check_flags("midreset_flags", 1'b0, 1'b0);
        reset_ = 1'b1;
        tick();
        check_flags("midreset_rfd", 1'b1, 1'b0);
        run_request("after_reset", 1'b0, 4, 2, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 25; n++) begin
            run_request("random", 1'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 7)),
                        1'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        exp_sat  = 128;
        exp_wrap = 128;
        reset_   = 1'b0;
        dav_n    = 1'b1;
        s_i      = 1'b0;
        h_i      = '0;
        k_i      = '0;
        m_i      = 1'b0;
        test_reset();
        test_basic_return();
        test_hold_mode();
        test_saturation();
        test_zero_length();
        test_reset_mid_ramp();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
